// File: rtl/conv_window_sequencer.sv
// KxK convolution window sequencer: fetches pixel/weight pairs over one memory port and accumulates signed products.
// Optional build macro CONV_RELU_EN clamps a negative final sum to zero.
module conv_window_sequencer #(
  parameter int KMAX   = 5,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] in_base,
  input  logic [ADDR_W-1:0] wt_base,
  input  logic [15:0]       img_w,
  input  logic [3:0]        ksize,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              stall,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_IN = 3'd1,
    S_RD_WT = 3'd2,
    S_MAC   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Handshake: mem_addr is presented with mem_req=1 and held unchanged until
  // the cycle mem_ack=1, in which mem_rdata is captured.

  state_t            r_state;
  logic [ADDR_W-1:0] r_in_base;
  logic [ADDR_W-1:0] r_wt_base;
  logic [15:0]       r_img_w;
  logic [3:0]        r_k;
  logic [3:0]        r_r;
  logic [3:0]        r_c;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_pix;
  logic [DATA_W-1:0] r_wt;
  logic              r_req;
  logic [ADDR_W-1:0] r_addr;
  logic              r_done;
  logic [DATA_W-1:0] r_result;

  logic [3:0]        w_k_eff;
  logic              w_last_c;
  logic              w_last;
  logic [3:0]        w_r_nxt;
  logic [3:0]        w_c_nxt;
  logic [DATA_W-1:0] w_prod;
  logic [DATA_W-1:0] w_sum;
  logic [ADDR_W-1:0] w_in_nxt;
  logic [ADDR_W-1:0] w_wt_addr;

  function automatic logic [DATA_W-1:0] f_out(input logic [DATA_W-1:0] a);
`ifdef CONV_RELU_EN
    return a[DATA_W-1] ? '0 : a;
`else
    return a;
`endif
  endfunction

  assign w_k_eff   = (ksize > 4'(KMAX)) ? 4'(KMAX) : ksize;
  assign w_last_c  = (r_c == r_k - 4'd1);
  assign w_last    = w_last_c && (r_r == r_k - 4'd1);
  assign w_c_nxt   = w_last_c ? 4'd0 : r_c + 4'd1;
  assign w_r_nxt   = w_last_c ? r_r + 4'd1 : r_r;
  // Low DATA_W bits of the signed product; the sum wraps without saturation.
  assign w_prod    = DATA_W'($signed(r_pix) * $signed(r_wt));
  assign w_sum     = r_acc + w_prod;
  assign w_in_nxt  = r_in_base + ((ADDR_W'(w_r_nxt) * ADDR_W'(r_img_w) + ADDR_W'(w_c_nxt)) << 2);
  assign w_wt_addr = r_wt_base + ((ADDR_W'(r_r) * ADDR_W'(r_k) + ADDR_W'(r_c)) << 2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_in_base <= '0;
      r_wt_base <= '0;
      r_img_w   <= '0;
      r_k       <= '0;
      r_r       <= '0;
      r_c       <= '0;
      r_acc     <= '0;
      r_pix     <= '0;
      r_wt      <= '0;
      r_req     <= 1'b0;
      r_addr    <= '0;
      r_done    <= 1'b0;
      r_result  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_in_base <= in_base;
            r_wt_base <= wt_base;
            r_img_w   <= img_w;
            r_k       <= w_k_eff;
            r_r       <= '0;
            r_c       <= '0;
            r_acc     <= '0;
            if (w_k_eff == 4'd0) begin
              r_result <= f_out('0);
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_req   <= 1'b1;
              r_addr  <= in_base;
              r_state <= S_RD_IN;
            end
          end
        end
        S_RD_IN: begin
          if (mem_ack) begin
            r_pix   <= mem_rdata;
            r_addr  <= w_wt_addr;
            r_state <= S_RD_WT;
          end
        end
        S_RD_WT: begin
          if (mem_ack) begin
            r_wt    <= mem_rdata;
            r_req   <= 1'b0;
            r_state <= S_MAC;
          end
        end
        S_MAC: begin
          r_acc <= w_sum;
          r_r   <= w_r_nxt;
          r_c   <= w_c_nxt;
          if (w_last) begin
            r_result <= f_out(w_sum);
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_req   <= 1'b1;
            r_addr  <= w_in_nxt;
            r_state <= S_RD_IN;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_req   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_req   = r_req;
  assign mem_addr  = r_addr;
  assign busy      = (r_state != S_IDLE);
  assign stall     = busy;
  assign done      = r_done;
  assign result    = r_result;
  assign dbg_state = r_state;

endmodule

// File: doc/conv_window_sequencer.md
Name: conv_window_sequencer

Overview:
- Multi-cycle controller that runs one KxK convolution window per custom conv instruction.
- Walks input-pixel and weight addresses, fetches operands over a single data-memory port, and accumulates signed products.
- Returns one 32-bit result and holds the pipeline stalled while active.
- Sits beside the execute stage; the decoder (ALUOp=2'b11 path) fires start; the writeback mux takes result on done.

Parameters:
- KMAX, 5, largest supported kernel edge; ksize above KMAX is clamped to KMAX.
- ADDR_W, 32, memory address width.
- DATA_W, 32, operand/accumulator width.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle request; sampled only in IDLE
- in_base  input  ADDR_W  byte address of window top-left pixel
- wt_base  input  ADDR_W  byte address of first weight (row-major, ksize*ksize words)
- img_w  input  16  image row width in words
- ksize  input  4  kernel edge, 0..15
- mem_req  output  1  read request to data memory
- mem_addr  output  ADDR_W  read byte address, word aligned
- mem_ack  input  1  read completes this cycle; mem_rdata valid
- mem_rdata  input  DATA_W  read data
- busy  output  1  high whenever state != IDLE
- stall  output  1  pipeline stall, equals busy
- done  output  1  one-cycle pulse, result valid
- result  output  DATA_W  accumulated window sum, held until next accepted start

Behaviour:
- Reset (async, any state): state=IDLE; mem_req=0, mem_addr=0, busy=stall=0, done=0, result=0; counters/accumulator cleared. Reset mid-window abandons the operation; no done pulse.
- Start sampling: in IDLE, start=1 latches in_base, wt_base, img_w, effective k=min(ksize,KMAX); clears acc, r, c; next state RD_IN. start outside IDLE is ignored.
- ksize=0: IDLE -> DONE directly; result=0; done pulses next cycle.
- RD_IN: mem_req=1, mem_addr = in_base + 4*(r*img_w + c). Hold address stable until mem_ack. On ack, latch pixel -> RD_WT.
- RD_WT: mem_req=1, mem_addr = wt_base + 4*(r*k + c). On ack, latch weight -> MAC.
- MAC: mem_req=0. acc <= acc + low DATA_W bits of signed(pixel)*signed(weight); wrap modulo 2^DATA_W, no saturation.
  - Counter step: c==k-1 -> c=0, r++.
  - Last element (r==k-1, c==k-1) -> DONE; else -> RD_IN.
- DONE: done=1 for exactly one cycle; result <= final acc (post-ReLU if enabled), updated on entry to DONE; -> IDLE.
- Latency: with mem_ack tied high, done is high in the cycle after edge 3*k*k counted from the start-sampling edge. Each ack wait cycle adds 1.
- mem_addr outside RD_IN/RD_WT retains its last value; mem_req low.
- Address arithmetic is computed modulo 2^ADDR_W.

Optional Feature:
- Macro CONV_RELU_EN.
- Defined: on entry to DONE, a negative acc (MSB=1) gives result=0; otherwise result=acc.
- Undefined: result=acc unmodified.
- Timing identical in both builds.

Test Plan:
- Reset mid-window: assert rst during RD_WT of element 2 -> same cycle busy=0, mem_req=0, result=0; no done pulse; next start runs normally.
- Basic 2x2, ack tied high: mem words at 0x100 = 1,2,3,...; weights at 0x200 = 1,-1,2,3; img_w=4, ksize=2.
  - Addresses 0x100,0x200,0x104,0x204,0x110,0x208,0x114,0x20C in order.
  - result=27; done in cycle after edge 12.
- Ack backpressure: same as basic 2x2 with mem_ack low 3 cycles on each read -> mem_addr stable while waiting; result=27; done 24 cycles later than baseline.
- ksize=0 -> zero memory requests, done 1 cycle after start, result=0. ksize=9 with KMAX=5 -> 25 element reads, then done.
- Negative sum: ksize=2, weights all -1 over pixels 1,2,5,6.
  - Without CONV_RELU_EN: result=0xFFFFFFF2.
  - With CONV_RELU_EN: result=0.
- start pulsed while busy -> ignored; latched bases unchanged; exactly one done per accepted start; result holds 27 until the next accepted start.
